// File: rtl/inst_rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_pkg
// Shared widths, bus levels and loader state encoding for the instruction
// ROM loader. Also holds the byte-placement helper used by the packer.
// ---------------------------------------------------------------------------
package inst_rom_loader_pkg;

    localparam int REG_WIDTH       = 32;   // RegBus
    localparam int INST_WIDTH      = 32;   // InstBus
    localparam int INST_ADDR_WIDTH = 32;   // InstAddrBus
    localparam int BYTES_PER_WORD  = 4;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b1;  // core held in reset
    localparam logic RST_DISABLE  = 1'b0;

    // LoadStateBus
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    // Big-endian placement: slot 0 is the first byte of a word (bits 31:24).
    function automatic logic [INST_WIDTH-1:0] place_byte(
        input logic [INST_WIDTH-1:0] word,
        input logic [1:0]            slot,
        input logic [7:0]            b
    );
        logic [INST_WIDTH-1:0] r;
        r = word;
        case (slot)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// ---------------------------------------------------------------------------
// inst_rom_mem
// Word-addressed instruction store: one synchronous write port and one
// asynchronous read port.
//   clk          system clock
//   we/waddr/wdata  write port, written on the rising edge when we=1
//   raddr/rdata  combinational read port
// ---------------------------------------------------------------------------
module inst_rom_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset; a reset would prevent RAM inference and
    // is unnecessary because reads are gated by the loaded word count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
// Instruction memory responder for the CPU fetch port, filled at runtime by a
// big-endian byte-stream loader. Holds the core in reset until a program has
// been loaded completely.
//   clk, rst          clock, asynchronous active-low reset
//   rom_ce_in         fetch enable from the core
//   rom_addr_in       byte address from the core PC
//   rom_data_out      fetched instruction (0 = NOP when not readable)
//   ld_start          pulse: begin (re)load at word 0
//   ld_valid/ld_ready byte handshake, ld_byte data, ld_last marks final byte
//   ld_err            sticky overflow flag, cleared by ld_start
//   loaded_words      words written by the current/last load
//   cpu_rst_out       core reset, high = hold
// ---------------------------------------------------------------------------
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_in,
    input  logic [31:0]           rom_addr_in,
    output logic [DATA_WIDTH-1:0] rom_data_out,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_err,
    output logic [ADDR_WIDTH:0]   loaded_words,
    output logic                  cpu_rst_out
);

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    load_state_e           state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [INST_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH:0]   loaded_q, loaded_d;
    logic                  err_q, err_d;
    logic                  cpu_rst_q;

    logic                  mem_we;
    logic [INST_WIDTH-1:0] word_with_byte;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  addr_in_range;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            wptr_q     <= '0;
            word_q     <= '0;
            loaded_q   <= '0;
            err_q      <= 1'b0;
            cpu_rst_q  <= RST_ENABLE;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wptr_q     <= wptr_d;
            word_q     <= word_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
            // Registered from the next state: released the cycle after the
            // final write, re-asserted the cycle after any ld_start.
            cpu_rst_q  <= (state_d == ST_RUN) ? RST_DISABLE : RST_ENABLE;
        end
    end

    assign word_with_byte = place_byte(word_q, byte_cnt_q, ld_byte);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wptr_d     = wptr_q;
        word_d     = word_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
        mem_we     = 1'b0;

        if (ld_start) begin
            // Restart wins over any byte offered in the same cycle.
            state_d    = ST_LOAD;
            byte_cnt_d = '0;
            wptr_d     = '0;
            word_d     = '0;
            loaded_d   = '0;
            err_d      = 1'b0;
        end else if (state_q == ST_LOAD && ld_valid) begin
            if (loaded_q == FULL) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
            end else if (byte_cnt_q == 2'd3 || ld_last) begin
                // Word complete (or truncated by ld_last, low bytes stay 0).
                mem_we     = 1'b1;
                wptr_d     = wptr_q + 1'b1;
                loaded_d   = loaded_q + 1'b1;
                byte_cnt_d = '0;
                word_d     = '0;
                if (ld_last) begin
                    state_d = ST_RUN;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                word_d     = word_with_byte;
            end
        end
    end

    inst_rom_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (DATA_WIDTH'(word_with_byte)),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    // Zero-latency fetch: the core captures rom_data on the same edge as the PC.
    assign rd_idx        = rom_addr_in[ADDR_WIDTH+1:2];
    assign addr_in_range = (rom_addr_in >> (ADDR_WIDTH + 2)) == 32'd0;

    always_comb begin
        rom_data_out = '0;
        if (state_q == ST_RUN && rom_ce_in == CHIP_ENABLE && addr_in_range
            && ({1'b0, rd_idx} < loaded_q)) begin
            rom_data_out = mem_rdata;
        end
    end

    assign ld_ready     = (state_q == ST_LOAD);
    assign ld_err       = err_q;
    assign loaded_words = loaded_q;
    assign cpu_rst_out  = cpu_rst_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_loader
// Randomized bench with a behavioural model of the program store. Fetch
// expectations are queued by the stimulus and compared by a monitor on the
// falling edge. A second instance with a 4-word store exercises overflow.
// ---------------------------------------------------------------------------
module tb_inst_rom_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int SAW   = 2;

    typedef logic [7:0] u8_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_in;
    logic [31:0] rom_addr_in;
    logic        ld_start, s_ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;

    logic [31:0] rom_data_out, s_rom_data_out;
    logic        ld_ready, s_ld_ready;
    logic        ld_err, s_ld_err;
    logic [AW:0] loaded_words;
    logic [SAW:0] s_loaded_words;
    logic        cpu_rst_out, s_cpu_rst_out;

    inst_rom_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rom_ce_in(rom_ce_in), .rom_addr_in(rom_addr_in),
        .rom_data_out(rom_data_out), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready), .ld_err(ld_err),
        .loaded_words(loaded_words), .cpu_rst_out(cpu_rst_out)
    );

    inst_rom_loader #(.ADDR_WIDTH(SAW), .DATA_WIDTH(32)) dut_small (
        .clk(clk), .rst(rst), .rom_ce_in(rom_ce_in), .rom_addr_in(rom_addr_in),
        .rom_data_out(s_rom_data_out), .ld_start(s_ld_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(s_ld_ready), .ld_err(s_ld_err),
        .loaded_words(s_loaded_words), .cpu_rst_out(s_cpu_rst_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_lw;       // words written by the current/last load
    bit          m_run;      // a complete program is present
    bit          m_loading;  // loader accepting bytes

    function automatic logic [31:0] pack(input u8_t q[$], input int w);
        logic [31:0] word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            int idx = 4 * w + k;
            word = {word[23:0], (idx < q.size()) ? q[idx] : 8'h00};
        end
        return word;
    endfunction

    function automatic logic [31:0] exp_fetch(input bit ce, input logic [31:0] addr);
        if (m_run && ce && (64'(addr) < 64'(4 * m_lw))) return m_mem[addr >> 2];
        return 32'h0;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic        fetch_req = 1'b0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (fetch_req) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL fetch: got %0h with no expected value queued", rom_data_out);
            end else begin
                check($sformatf("fetch@%0h", rom_addr_in), rom_data_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input bit ce, input logic [31:0] addr);
        rom_ce_in   = ce;
        rom_addr_in = addr;
        fetch_req   = 1'b1;
        exp_q.push_back(exp_fetch(ce, addr));
        tick();
        fetch_req   = 1'b0;
        rom_ce_in   = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ":cpu_rst"}, cpu_rst_out, m_run ? 1'b0 : 1'b1);
        check({tag, ":ld_ready"}, ld_ready, m_loading);
        check({tag, ":loaded_words"}, loaded_words, m_lw);
        check({tag, ":ld_err"}, ld_err, 1'b0);
    endtask

    task automatic pulse_start(input bit with_byte);
        ld_start = 1'b1;
        if (with_byte) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
        end
        tick();
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        m_run     = 0;
        m_loading = 1;
        m_lw      = 0;
    endtask

    task automatic send_load(input u8_t bq[$], input bit use_last);
        int n = bq.size();
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            ld_valid = 1'b1;
            ld_byte  = bq[i];
            ld_last  = use_last && (i == n - 1);
            check_status("loading");
            tick();
            if (ld_last || (i % 4) == 3) begin
                m_mem[m_lw] = pack(bq, m_lw);
                m_lw++;
            end
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
        if (use_last) begin
            m_run     = 1;
            m_loading = 0;
        end
        check_status("after_load");
    endtask

    task automatic random_fetches(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] addr;
            bit ce = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'h1000 | 32'($urandom_range(0, 4095));
                default: addr = (32'($urandom_range(0, m_lw + 1)) << 2) | 32'($urandom_range(0, 3));
            endcase
            do_fetch(ce, addr);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        u8_t bq[$];

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_lw = 0; m_run = 0; m_loading = 0;
        rst = 1'b0; rom_ce_in = 1'b0; rom_addr_in = '0;
        ld_start = 1'b0; s_ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;

        tick(); tick();
        check_status("in_reset");
        rst = 1'b1;
        tick();
        check_status("idle");
        do_fetch(1'b1, 32'h0);

        // Directed program: two full words, ld_last on a 4th byte.
        pulse_start(1'b0);
        bq = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
        send_load(bq, 1'b1);
        do_fetch(1'b1, 32'h0);
        do_fetch(1'b1, 32'h4);
        do_fetch(1'b1, 32'h7);
        do_fetch(1'b1, 32'h8);
        do_fetch(1'b0, 32'h0);
        do_fetch(1'b1, 32'h0000_1000);
        check("dir_word0", m_mem[0], 32'h3401_0005);

        // Directed truncated word: low bytes padded with zero.
        pulse_start(1'b0);
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_load(bq, 1'b1);
        do_fetch(1'b1, 32'h0);
        do_fetch(1'b1, 32'h4);

        // Restart mid-run with a coinciding byte that must be discarded.
        pulse_start(1'b1);
        check_status("restart");
        do_fetch(1'b1, 32'h0);
        bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        send_load(bq, 1'b1);
        do_fetch(1'b1, 32'h0);
        do_fetch(1'b1, 32'h4);

        // Randomized loads, some abandoned by a restart.
        for (int it = 0; it < 10; it++) begin
            int  len   = $urandom_range(1, 40);
            bit  abort = ($urandom_range(0, 3) == 0);
            pulse_start($urandom_range(0, 1) == 1);
            bq.delete();
            for (int b = 0; b < len; b++) bq.push_back(8'($urandom));
            send_load(bq, !abort);
            if (abort) begin
                do_fetch(1'b1, 32'h0);
            end else begin
                random_fetches(20);
            end
        end

        // Reset during the 3rd byte of a load.
        pulse_start(1'b0);
        bq = '{8'hDE, 8'hAD};
        send_load(bq, 1'b0);
        ld_valid = 1'b1;
        ld_byte  = 8'hBE;
        rom_ce_in = 1'b1;
        rom_addr_in = 32'h0;
        #2 rst = 1'b0;
        #1;
        m_run = 0; m_loading = 0; m_lw = 0;
        check_status("mid_load_reset");
        check("mid_load_reset:rom", rom_data_out, 32'h0);
        ld_valid = 1'b0;
        rom_ce_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_status("post_reset");
        pulse_start(1'b0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_load(bq, 1'b1);
        do_fetch(1'b1, 32'h0);
        do_fetch(1'b1, 32'h4);

        // Overflow on the 4-word instance; main instance stays in RUN.
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        check("ovf:ready", s_ld_ready, 1'b1);
        for (int i = 0; i < 17; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            if (i == 16) begin
                check("ovf:words_before", s_loaded_words, 4);
                check("ovf:err_before", s_ld_err, 1'b0);
            end
            tick();
            ld_valid = 1'b0;
        end
        check("ovf:err", s_ld_err, 1'b1);
        check("ovf:cpu_rst", s_cpu_rst_out, 1'b1);
        check("ovf:ready_low", s_ld_ready, 1'b0);
        check("ovf:words", s_loaded_words, 4);
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        rom_ce_in = 1'b1;
        rom_addr_in = 32'h0;
        tick();
        check("ovf:sticky", s_ld_err, 1'b1);
        check("ovf:rom", s_rom_data_out, 32'h0);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rom_ce_in = 1'b0;
        check_status("main_during_ovf");
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        check("ovf:err_cleared", s_ld_err, 1'b0);
        check("ovf:words_cleared", s_loaded_words, 0);
        check("ovf:reload_ready", s_ld_ready, 1'b1);

        tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard: %0d expected fetches left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder on the far side of the CPU fetch interface: receives rom_ce/rom_addr and returns rom_data.
- Contains a word-addressed instruction store filled at runtime by a byte-stream loader (valid/ready) and gates the core's reset until a program is loaded.
- Sits at SoC top level beside cpu; the loader port connects to the host/debug link.

Parameters:
ADDR_WIDTH, 10, word-index width; store depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width (fixed at 32; byte count per word = 4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rom_ce_in  input  1  fetch enable from core (`ChipEnable`)
rom_addr_in  input  32  byte address from core PC
rom_data_out  output  32  fetched instruction
ld_start  input  1  one-cycle pulse: begin (re)load at word 0
ld_valid  input  1  loader byte valid
ld_byte  input  8  loader byte, big-endian (first byte → bits 31:24)
ld_last  input  1  qualifies final byte of program
ld_ready  output  1  loader may transfer a byte
ld_err  output  1  overflow sticky flag
loaded_words  output  ADDR_WIDTH+1  count of words written in last load
cpu_rst_out  output  1  core reset, asserted level `RstEnable` (high = hold)

Behaviour:
- States: IDLE, LOAD, RUN, ERR. All state elements reset asynchronously on rst=0.
- Reset values: state=IDLE, cpu_rst_out=1, ld_ready=0, ld_err=0, loaded_words=0, byte counter=0, word pointer=0, shift register=0. Store contents are not cleared.
- IDLE:
  - cpu held; rom_data_out=0.
  - ld_start → LOAD.
- LOAD entry (ld_start in any state, including LOAD itself):
  - Word pointer, byte counter, shift register and loaded_words are zeroed; ld_err is cleared.
  - cpu_rst_out=1 from the next cycle.
- LOAD:
  - ld_ready=1. A transfer happens when ld_valid & ld_ready.
  - Each transfer shifts the byte in MSB-first and increments the byte counter (mod 4).
  - On the 4th byte: the assembled word is written to mem[wptr] at that edge, then wptr and loaded_words increment.
  - ld_last on a transfer:
    - The current word is written, with unfilled low bytes set to 0x00.
    - loaded_words increments; state → RUN.
    - If ld_last falls on a 4th byte, exactly one write occurs.
  - Overflow: a transfer arriving when loaded_words == 2**ADDR_WIDTH → no write; state → ERR; ld_err=1.
  - ld_start coinciding with a transfer: ld_start wins and the byte is discarded.
  - rom_data_out=0 throughout LOAD.
- RUN:
  - cpu_rst_out deasserts (registered, so it goes low the cycle after the final write).
  - ld_ready=0.
  - Fetch read is combinational, zero latency, because the core captures rom_data in its IF/ID register on the same edge as the PC.
  - Read rule: rom_data_out = mem[rom_addr_in[ADDR_WIDTH+1:2]] when all of these hold; otherwise 32'h0 (NOP):
    - rom_ce_in == `ChipEnable`
    - rom_addr_in[31:ADDR_WIDTH+2] == 0
    - word index < loaded_words
  - rom_addr_in[1:0] is ignored.
- ERR:
  - cpu held; ld_ready=0; rom_data_out=0.
  - Only ld_start exits.
- Write-to-read visibility: a word written at edge k is readable from cycle k+1.
- Reset mid-load: the load is abandoned and the block returns to IDLE with the core held.

Decomposition:
- Shared defines header: `RegBus`, `InstBus`, `InstAddrBus`, `ChipEnable`/`ChipDisable`, `RstEnable`/`RstDisable`, plus new `LoadStateBus` and state encodings.
- Sub-module inst_rom_mem:
  - 2**ADDR_WIDTH × 32 array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on the array.
- FSM, byte packer and address-range check stay in inst_rom_loader.

Test Plan:
- Reset, then ce=1, addr=0 with no load → rom_data_out=0, cpu_rst_out=1, ld_ready=0, state IDLE.
- ld_start; bytes 34 01 00 05 24 02 00 07 with ld_last on byte 8 → mem[0]=0x34010005, mem[1]=0x24020007, loaded_words=2; cpu_rst_out=0 one cycle after the last byte; addr=0x4 → 0x24020007; addr=0x8 → 0.
- Load of 6 bytes AA BB CC DD 11 22, ld_last on byte 6 → mem[1]=0x11220000, loaded_words=2.
- ADDR_WIDTH=2, stream 17 bytes → 4 words written; byte 17 sets ld_err=1, state ERR, cpu stays held; subsequent ld_start clears ld_err.
- In RUN: ce=0 → 0; addr=0x0000_1000 (above range) → 0; ld_start mid-run → cpu_rst_out=1 next cycle, rom_data_out=0, loaded_words=0.
- rst=0 asserted during the 3rd byte of a load → outputs immediately at reset values; no partial word written.
